// File: rtl/bus_mem_slave.sv
// Windowed byte memory slave for the 6502-style bus with a programmable number of wait states.
// Defining MEM_WRITE_PROTECT_EN write-protects the top ROM_SIZE entries of the window.
module bus_mem_slave #(
   parameter int unsigned            ADDR_WIDTH  = 16,
   parameter int unsigned            DATA_WIDTH  = 8,
   parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR   = '0,
   parameter int unsigned            DEPTH       = 2048,
   parameter int unsigned            WAIT_STATES = 0,
   parameter int unsigned            ROM_SIZE    = 0
) (
   input  logic                  phi0,
   input  logic                  reset_n,
   input  logic [ADDR_WIDTH-1:0] A,
   input  logic                  R_W_n,
   input  logic [DATA_WIDTH-1:0] d_in,
   output logic [DATA_WIDTH-1:0] d_out,
   output logic                  d_oe,
   output logic                  rdy,
   output logic                  wp_err,
   output logic [15:0]           access_cnt
);

   localparam int unsigned IDX_W = $clog2(DEPTH);

   // Window size held one bit wider so a window ending at the top of the address space decodes.
   localparam logic [ADDR_WIDTH:0] DEPTH_W  = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [3:0]          CNT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

`ifdef MEM_WRITE_PROTECT_EN
   localparam int unsigned ROM_EFF = ROM_SIZE;
`else
   localparam int unsigned ROM_EFF = ROM_SIZE * 0;
`endif
   // With an empty protected region the comparison never matches and wp_err stays low.
   localparam logic [IDX_W:0] ROM_START = (IDX_W+1)'(DEPTH - ROM_EFF);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic                    rw_q, rw_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0]   d_out_q, d_out_d;
   logic                    d_oe_q, d_oe_d;
   logic                    rdy_q, rdy_d;
   logic                    wp_err_q, wp_err_d;
   logic [15:0]             access_cnt_q, access_cnt_d;

   logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

   logic [ADDR_WIDTH-1:0]   offset;
   logic                    hit;
   logic [IDX_W-1:0]        bus_idx;
   logic                    do_access;
   logic                    mem_we;
   logic [IDX_W-1:0]        acc_idx;
   logic                    acc_rw;
   logic [DATA_WIDTH-1:0]   acc_wdata;

   assign offset  = A - BASE_ADDR;
   assign hit     = ({1'b0, offset} < DEPTH_W);
   assign bus_idx = offset[IDX_W-1:0];

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      rw_d         = rw_q;
      wdata_d      = wdata_q;
      d_out_d      = d_out_q;
      d_oe_d       = 1'b0;
      wp_err_d     = 1'b0;
      access_cnt_d = access_cnt_q;
      do_access    = 1'b0;
      mem_we       = 1'b0;
      acc_idx      = idx_q;
      acc_rw       = rw_q;
      acc_wdata    = wdata_q;

      case (state_q)
         WAIT: begin
            if (cnt_q == 4'd0) begin
               do_access = 1'b1;
               state_d   = DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            if (hit) begin
               idx_d   = bus_idx;
               rw_d    = R_W_n;
               wdata_d = d_in;
               if (WAIT_STATES == 0) begin
                  do_access = 1'b1;
                  acc_idx   = bus_idx;
                  acc_rw    = R_W_n;
                  acc_wdata = d_in;
                  state_d   = DONE;
               end else begin
                  cnt_d   = CNT_LOAD;
                  state_d = WAIT;
               end
            end else begin
               state_d = IDLE;
            end
         end
      endcase

      // Discarded protected writes still count as completed accesses.
      if (do_access) begin
         access_cnt_d = access_cnt_q + 16'd1;
         if (acc_rw) begin
            d_out_d = mem_q[acc_idx];
            d_oe_d  = 1'b1;
         end else if ({1'b0, acc_idx} >= ROM_START) begin
            wp_err_d = 1'b1;
         end else begin
            mem_we = 1'b1;
         end
      end

      rdy_d = (state_d != WAIT);
   end

   always_ff @(posedge phi0 or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         cnt_q        <= 4'd0;
         idx_q        <= '0;
         rw_q         <= 1'b1;
         wdata_q      <= '0;
         d_out_q      <= '0;
         d_oe_q       <= 1'b0;
         rdy_q        <= 1'b1;
         wp_err_q     <= 1'b0;
         access_cnt_q <= 16'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         rw_q         <= rw_d;
         wdata_q      <= wdata_d;
         d_out_q      <= d_out_d;
         d_oe_q       <= d_oe_d;
         rdy_q        <= rdy_d;
         wp_err_q     <= wp_err_d;
         access_cnt_q <= access_cnt_d;
      end
   end

   // Contents survive reset; writes are gated so nothing commits while reset is held.
   always_ff @(posedge phi0) begin
      if (mem_we && reset_n) begin
         mem_q[acc_idx] <= acc_wdata;
      end
   end

   assign d_out      = d_out_q;
   assign d_oe       = d_oe_q;
   assign rdy        = rdy_q;
   assign wp_err     = wp_err_q;
   assign access_cnt = access_cnt_q;

endmodule
